// File: rtl/waterfall_pkg.sv
// Shared types and pattern lookup for the 8-LED waterfall generator.
package waterfall_pkg;

  typedef enum logic [1:0] {OFF, LEFT, RIGHT, FILL} mode_t;

  localparam int LED_W      = 8;
  localparam int DOT_STEPS  = 8;
  localparam int FILL_STEPS = 9;

  // FILL uses an inverted left shift so idx 8 naturally yields all ones.
  function automatic logic [LED_W-1:0] pattern(mode_t m, logic [3:0] idx);
    case (m)
      LEFT:    pattern = 8'h01 << idx[2:0];
      RIGHT:   pattern = 8'h80 >> idx[2:0];
      FILL:    pattern = ~(8'hFF << idx);
      default: pattern = '0;
    endcase
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
module led_prescaler #(
  parameter int CLK_DIV = 25_000_000,
  parameter int CNT_W   = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/waterfall_led.sv
// Waterfall LED pattern generator: mode decode, step index and registered LED drive.
module waterfall_led
  import waterfall_pkg::*;
#(
  parameter int CLK_DIV = 25_000_000,
  parameter int CNT_W   = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g1,
  input  logic             g2,
  input  logic             g3,
  input  logic             clr_n,
  input  logic             stop_n,
  output logic [LED_W-1:0] y
);

  mode_t      mode, mode_dec, mode_nxt;
  logic [3:0] idx, idx_nxt, idx_last;
  logic       mode_chg, restart, run, tick;

  always_comb begin
    mode_dec = OFF;
    if      (g1) mode_dec = LEFT;
    else if (g2) mode_dec = RIGHT;
    else if (g3) mode_dec = FILL;
  end

  // A clear on the same edge as a mode change wins; the new mode lands next edge.
  assign mode_chg = clr_n && (mode_dec != mode);
  assign restart  = !clr_n || mode_chg;
  assign run      = stop_n && (mode != OFF);
  assign mode_nxt = mode_chg ? mode_dec : mode;
  assign idx_last = (mode == FILL) ? 4'(FILL_STEPS - 1) : 4'(DOT_STEPS - 1);

  always_comb begin
    idx_nxt = idx;
    if (restart)   idx_nxt = '0;
    else if (tick) idx_nxt = (idx == idx_last) ? 4'd0 : idx + 4'd1;
  end

  led_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (restart),
    .en   (run),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode <= OFF;
      idx  <= '0;
      y    <= '0;
    end else begin
      mode <= mode_nxt;
      idx  <= idx_nxt;
      y    <= pattern(mode_nxt, idx_nxt);
    end
  end

endmodule

// File: tb/tb_waterfall_led.sv
// Bench for waterfall_led at CLK_DIV=4: directed steps plus random inputs against an elapsed-cycle model.
module tb_waterfall_led;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, g1, g2, g3, clr_n, stop_n;
  logic [7:0] y;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: active mode (0 off,1 left,2 right,3 fill) and cycles counted since last restart.
  int         m_mode = 0;
  int         m_el   = 0;
  logic [7:0] exp_y  = 8'h00;

  waterfall_led #(.CLK_DIV(DIV), .CNT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .g1     (g1),
    .g2     (g2),
    .g3     (g3),
    .clr_n  (clr_n),
    .stop_n (stop_n),
    .y      (y)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_pat(int md, int steps);
    case (md)
      1:       return 8'(1 << (steps % 8));
      2:       return 8'(128 >> (steps % 8));
      3:       return 8'((1 << (steps % 9)) - 1);
      default: return 8'h00;
    endcase
  endfunction

  task automatic step(string tag);
    int dec;
    @(posedge clk);
    dec = g1 ? 1 : g2 ? 2 : g3 ? 3 : 0;
    if (rst) begin
      m_mode = 0; m_el = 0;
    end else if (!clr_n) begin
      m_el = 0;
    end else if (dec != m_mode) begin
      m_mode = dec; m_el = 0;
    end else if (stop_n && m_mode != 0) begin
      m_el++;
    end
    exp_y = ref_pat(m_mode, m_el / DIV);
    #1;
    n_chk++;
    assert (y === exp_y) else begin
      n_fail++;
      $error("FAIL %s: y=%h expected %h", tag, y, exp_y);
    end
  endtask

  task automatic run(int n, string tag);
    repeat (n) step(tag);
  endtask

  task automatic chk_const(string tag, logic [7:0] v);
    n_chk++;
    assert (y === v) else begin
      n_fail++;
      $error("FAIL %s: y=%h expected %h", tag, y, v);
    end
  endtask

  initial begin
    rst = 1; g1 = 1; g2 = 0; g3 = 0; clr_n = 1; stop_n = 1;
    run(3, "reset");
    chk_const("reset_y", 8'h00);
    rst = 0;
    step("release");
    chk_const("first_left", 8'h01);
    run(35, "left");
    chk_const("left_wrap", 8'h01);

    g2 = 1;
    run(5, "prio");
    g1 = 0;
    step("to_right");
    chk_const("right0", 8'h80);
    run(3, "right");
    chk_const("right_hold", 8'h80);
    step("right");
    chk_const("right1", 8'h40);

    g2 = 0; g3 = 1;
    step("to_fill");
    chk_const("fill0", 8'h00);
    run(32, "fill");
    chk_const("fill_full", 8'hFF);
    run(4, "fill");
    chk_const("fill_wrap", 8'h00);

    g3 = 0; g1 = 1;
    step("to_left");
    run(5, "left");
    stop_n = 0;
    run(10, "stop");
    chk_const("stop_frozen", 8'h02);
    stop_n = 1;
    run(2, "resume");
    chk_const("resume_rest", 8'h02);
    step("resume");
    chk_const("resume_adv", 8'h04);

    run(8, "left");
    chk_const("pre_clr", 8'h10);
    clr_n = 0;
    step("clr");
    chk_const("clr_y", 8'h01);
    clr_n = 1;
    run(3, "post_clr");
    chk_const("post_clr_hold", 8'h01);
    step("post_clr");
    chk_const("post_clr_adv", 8'h02);
    g1 = 0;
    step("to_off");
    chk_const("off_y", 8'h00);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        g1 = 1'($urandom_range(0, 3) == 0);
        g2 = 1'($urandom_range(0, 1));
        g3 = 1'($urandom_range(0, 1));
      end
      clr_n  = ($urandom_range(0, 39) != 0);
      stop_n = ($urandom_range(0, 7) != 0);
      rst    = ($urandom_range(0, 149) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
